// File: rtl/cva6_store_unit_pkg.sv
// Shared types and constants for the RV32 CVA6 store unit slice.
package cva6_store_unit_pkg;

  localparam logic [7:0]  SW = 8'd39;
  localparam logic [7:0]  SH = 8'd40;
  localparam logic [7:0]  SB = 8'd41;
  localparam logic [31:0] STORE_ADDR_MISALIGNED = 32'd6;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TRANSLATION,
    WAIT_STORE_READY
  } st_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] vaddr;
    logic        overflow;
    logic [31:0] data;
    logic [3:0]  be;
    logic [3:0]  fu;
    logic [7:0]  operation;
    logic [2:0]  trans_id;
  } lsu_ctrl_t;

  typedef struct packed {
    logic [31:0] cause;
    logic [31:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        data_ruser;
  } dcache_req_i_t;

  typedef struct packed {
    logic [11:0] address_index;
    logic [21:0] address_tag;
    logic [31:0] data_wdata;
    logic        data_wuser;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [1:0]  data_size;
    logic        kill_req;
    logic        tag_valid;
  } dcache_req_o_t;

  typedef struct packed {
    logic        req;
    logic [3:0]  amo_op;
    logic [1:0]  size;
    logic [63:0] operand_a;
    logic [63:0] operand_b;
  } amo_req_t;

  typedef struct packed {
    logic        ack;
    logic [63:0] result;
  } amo_resp_t;

  typedef struct packed {
    logic [33:0] paddr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [1:0]  size;
  } sb_entry_t;

  // Anything that is not SH/SB is handled as a full word store.
  function automatic logic [1:0] op_size(input logic [7:0] op);
    case (op)
      SH:      return 2'd1;
      SB:      return 2'd0;
      default: return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/cva6_store_unit_store_buffer.sv
// Speculative and commit store queues, drain to the D$ port, and load-offset hazard match.
module cva6_store_unit_store_buffer
  import cva6_store_unit_pkg::*;
#(
  parameter int unsigned DEPTH_SPEC   = 4,
  parameter int unsigned DEPTH_COMMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        push_i,
  input  sb_entry_t   push_data_i,
  output logic        spec_full_o,
  input  logic        commit_i,
  output logic        commit_ready_o,
  input  logic        gnt_i,
  output logic        head_valid_o,
  output sb_entry_t   head_o,
  input  logic [11:0] page_offset_i,
  input  logic        cand_valid_i,
  input  logic [11:0] cand_offset_i,
  output logic        page_offset_matches_o,
  output logic        no_st_pending_o,
  output logic        store_buffer_empty_o
);

  localparam int unsigned SPW = (DEPTH_SPEC > 1) ? $clog2(DEPTH_SPEC) : 1;
  localparam int unsigned CPW = (DEPTH_COMMIT > 1) ? $clog2(DEPTH_COMMIT) : 1;
  localparam int unsigned SCW = $clog2(DEPTH_SPEC + 1);
  localparam int unsigned CCW = $clog2(DEPTH_COMMIT + 1);

  sb_entry_t               r_spec [DEPTH_SPEC];
  logic [DEPTH_SPEC-1:0]   r_spec_vld;
  logic [SPW-1:0]          r_spec_rd, r_spec_wr;
  logic [SCW-1:0]          r_spec_cnt;

  sb_entry_t               r_com [DEPTH_COMMIT];
  logic [DEPTH_COMMIT-1:0] r_com_vld;
  logic [CPW-1:0]          r_com_rd, r_com_wr;
  logic [CCW-1:0]          r_com_cnt;

  logic w_move, w_pop, w_match, w_unused;

  assign spec_full_o          = (r_spec_cnt == SCW'(DEPTH_SPEC));
  assign commit_ready_o       = (r_com_cnt != CCW'(DEPTH_COMMIT));
  assign w_move               = commit_i && commit_ready_o && (r_spec_cnt != '0);
  assign w_pop                = gnt_i && (r_com_cnt != '0);
  assign head_valid_o         = (r_com_cnt != '0);
  assign head_o               = r_com[r_com_rd];
  assign no_st_pending_o      = (r_com_cnt == '0);
  assign store_buffer_empty_o = (r_com_cnt == '0) && (r_spec_cnt == '0);
  assign w_unused             = ^{page_offset_i[1:0], cand_offset_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (push_i) r_spec[r_spec_wr] <= push_data_i;
    if (w_move) r_com[r_com_wr]   <= r_spec[r_spec_rd];
  end

  // A commit in the flush cycle still moves the head; the flush only drops what remains.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_spec_vld <= '0;
      r_spec_rd  <= '0;
      r_spec_wr  <= '0;
      r_spec_cnt <= '0;
    end else if (flush_i) begin
      r_spec_vld <= '0;
      r_spec_rd  <= '0;
      r_spec_wr  <= '0;
      r_spec_cnt <= '0;
    end else begin
      if (push_i) begin
        r_spec_vld[r_spec_wr] <= 1'b1;
        r_spec_wr <= (r_spec_wr == SPW'(DEPTH_SPEC - 1)) ? '0 : r_spec_wr + 1'b1;
      end
      if (w_move) begin
        r_spec_vld[r_spec_rd] <= 1'b0;
        r_spec_rd <= (r_spec_rd == SPW'(DEPTH_SPEC - 1)) ? '0 : r_spec_rd + 1'b1;
      end
      r_spec_cnt <= r_spec_cnt + SCW'(push_i) - SCW'(w_move);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_com_vld <= '0;
      r_com_rd  <= '0;
      r_com_wr  <= '0;
      r_com_cnt <= '0;
    end else begin
      if (w_move) begin
        r_com_vld[r_com_wr] <= 1'b1;
        r_com_wr <= (r_com_wr == CPW'(DEPTH_COMMIT - 1)) ? '0 : r_com_wr + 1'b1;
      end
      if (w_pop) begin
        r_com_vld[r_com_rd] <= 1'b0;
        r_com_rd <= (r_com_rd == CPW'(DEPTH_COMMIT - 1)) ? '0 : r_com_rd + 1'b1;
      end
      r_com_cnt <= r_com_cnt + CCW'(w_move) - CCW'(w_pop);
    end
  end

  always_comb begin
    w_match = cand_valid_i && (cand_offset_i[11:2] == page_offset_i[11:2]);
    for (int unsigned i = 0; i < DEPTH_SPEC; i++) begin
      if (r_spec_vld[i] && (r_spec[i].paddr[11:2] == page_offset_i[11:2])) w_match = 1'b1;
    end
    for (int unsigned i = 0; i < DEPTH_COMMIT; i++) begin
      if (r_com_vld[i] && (r_com[i].paddr[11:2] == page_offset_i[11:2])) w_match = 1'b1;
    end
  end

  assign page_offset_matches_o = w_match;

endmodule

// File: rtl/cva6_store_unit.sv
// Store unit top: translation handshake FSM, alignment check, writeback, D$ request mapping.
module cva6_store_unit
  import cva6_store_unit_pkg::*;
#(
  parameter int unsigned DEPTH_SPEC         = 4,
  parameter int unsigned DEPTH_COMMIT       = 4,
  parameter int unsigned TRANS_ID_BITS      = 3,
  parameter int unsigned XLEN               = 32,
  parameter int unsigned PLEN               = 34,
  parameter int unsigned DCACHE_INDEX_WIDTH = 12,
  parameter int unsigned DCACHE_TAG_WIDTH   = 22
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  output logic                          no_st_pending_o,
  output logic                          store_buffer_empty_o,
  input  logic                          valid_i,
  input  lsu_ctrl_t                     lsu_ctrl_i,
  output logic                          pop_st_o,
  input  logic                          commit_i,
  output logic                          commit_ready_o,
  input  logic                          amo_valid_commit_i,
  output logic                          valid_o,
  output logic [TRANS_ID_BITS-1:0]      trans_id_o,
  output logic [XLEN-1:0]               result_o,
  output exception_t                    ex_o,
  output logic                          translation_req_o,
  output logic [XLEN-1:0]               vaddr_o,
  input  logic [PLEN-1:0]               paddr_i,
  input  exception_t                    ex_i,
  input  logic                          dtlb_hit_i,
  input  logic [DCACHE_INDEX_WIDTH-1:0] page_offset_i,
  output logic                          page_offset_matches_o,
  output amo_req_t                      amo_req_o,
  input  amo_resp_t                     amo_resp_i,
  input  dcache_req_i_t                 req_port_i,
  output dcache_req_o_t                 req_port_o
);

  st_state_e                r_state, w_state_n;
  lsu_ctrl_t                r_op, w_op;
  logic                     r_valid;
  logic [TRANS_ID_BITS-1:0] r_trans_id;
  exception_t               r_ex, w_ex;
  logic                     w_pending, w_accept, w_misaligned, w_push, w_spec_full;
  logic [1:0]               w_size;
  sb_entry_t                w_entry, w_head;
  logic                     w_head_valid, w_unused;

  // While waiting, the op latched on entry is used; issue keeps presenting it until pop.
  assign w_op      = (r_state == IDLE) ? lsu_ctrl_i : r_op;
  assign w_pending = (r_state == IDLE) ? valid_i : 1'b1;
  assign w_size    = op_size(w_op.operation);

  assign w_misaligned = ((w_size == 2'd2) && (w_op.vaddr[1:0] != 2'b00)) ||
                        ((w_size == 2'd1) && w_op.vaddr[0]);
  assign w_push       = w_accept && !w_misaligned && !ex_i.valid;

  always_comb begin
    w_entry       = '0;
    w_entry.paddr = paddr_i;
    w_entry.data  = w_op.data << {w_op.vaddr[1:0], 3'b000};
    w_entry.be    = w_op.be;
    w_entry.size  = w_size;
  end

  always_comb begin
    w_ex = '0;
    if (w_misaligned) begin
      w_ex.cause = STORE_ADDR_MISALIGNED;
      w_ex.tval  = w_op.vaddr;
      w_ex.valid = 1'b1;
    end else if (ex_i.valid) begin
      w_ex = ex_i;
    end
  end

  always_comb begin
    w_state_n         = r_state;
    w_accept          = 1'b0;
    translation_req_o = 1'b0;
    vaddr_o           = '0;
    if (w_pending) begin
      translation_req_o = 1'b1;
      vaddr_o           = w_op.vaddr;
      w_accept          = dtlb_hit_i && !w_spec_full && !flush_i;
    end
    if (flush_i || !w_pending || w_accept) w_state_n = IDLE;
    else if (!dtlb_hit_i)                  w_state_n = WAIT_TRANSLATION;
    else                                   w_state_n = WAIT_STORE_READY;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_op       <= '0;
      r_valid    <= 1'b0;
      r_trans_id <= '0;
      r_ex       <= '0;
    end else begin
      r_state <= w_state_n;
      if ((r_state == IDLE) && valid_i && !w_accept) r_op <= lsu_ctrl_i;
      r_valid    <= w_accept;
      r_trans_id <= w_accept ? w_op.trans_id : '0;
      r_ex       <= w_accept ? w_ex : '0;
    end
  end

  cva6_store_unit_store_buffer #(
    .DEPTH_SPEC   (DEPTH_SPEC),
    .DEPTH_COMMIT (DEPTH_COMMIT)
  ) u_store_buffer (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .flush_i               (flush_i),
    .push_i                (w_push),
    .push_data_i           (w_entry),
    .spec_full_o           (w_spec_full),
    .commit_i              (commit_i),
    .commit_ready_o        (commit_ready_o),
    .gnt_i                 (req_port_i.data_gnt),
    .head_valid_o          (w_head_valid),
    .head_o                (w_head),
    .page_offset_i         (page_offset_i),
    .cand_valid_i          (w_accept),
    .cand_offset_i         (w_op.vaddr[11:0]),
    .page_offset_matches_o (page_offset_matches_o),
    .no_st_pending_o       (no_st_pending_o),
    .store_buffer_empty_o  (store_buffer_empty_o)
  );

  always_comb begin
    req_port_o = '0;
    if (w_head_valid) begin
      req_port_o.address_index = w_head.paddr[DCACHE_INDEX_WIDTH-1:0];
      req_port_o.address_tag   = w_head.paddr[DCACHE_INDEX_WIDTH +: DCACHE_TAG_WIDTH];
      req_port_o.data_wdata    = w_head.data;
      req_port_o.data_be       = w_head.be;
      req_port_o.data_size     = w_head.size;
      req_port_o.data_req      = 1'b1;
      req_port_o.data_we       = 1'b1;
      req_port_o.tag_valid     = 1'b1;
    end
  end

  assign pop_st_o   = w_accept;
  assign valid_o    = r_valid;
  assign trans_id_o = r_trans_id;
  assign ex_o       = r_ex;
  assign result_o   = '0;
  assign amo_req_o  = '0;
  assign w_unused   = ^{amo_valid_commit_i, amo_resp_i, req_port_i.data_rvalid,
                        req_port_i.data_rdata, req_port_i.data_ruser,
                        w_op.valid, w_op.overflow, w_op.fu};

endmodule

// File: tb/tb_cva6_store_unit.sv
// Random and directed stimulus for cva6_store_unit, checked each cycle against a queue model.
`timescale 1ns/1ps
module tb_cva6_store_unit;
  import cva6_store_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_ni, flush_i, valid_i, commit_i, dtlb_hit_i, amo_valid_commit_i;
  lsu_ctrl_t     lsu_ctrl_i;
  logic [33:0]   paddr_i;
  exception_t    ex_i, ex_o;
  logic [11:0]   page_offset_i;
  amo_resp_t     amo_resp_i;
  dcache_req_i_t req_port_i;
  logic          no_st_pending_o, store_buffer_empty_o, pop_st_o, commit_ready_o;
  logic          valid_o, translation_req_o, page_offset_matches_o;
  logic [2:0]    trans_id_o;
  logic [31:0]   result_o, vaddr_o;
  amo_req_t      amo_req_o;
  dcache_req_o_t req_port_o;

  cva6_store_unit dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .no_st_pending_o(no_st_pending_o), .store_buffer_empty_o(store_buffer_empty_o),
    .valid_i(valid_i), .lsu_ctrl_i(lsu_ctrl_i), .pop_st_o(pop_st_o),
    .commit_i(commit_i), .commit_ready_o(commit_ready_o),
    .amo_valid_commit_i(amo_valid_commit_i), .valid_o(valid_o), .trans_id_o(trans_id_o),
    .result_o(result_o), .ex_o(ex_o), .translation_req_o(translation_req_o),
    .vaddr_o(vaddr_o), .paddr_i(paddr_i), .ex_i(ex_i), .dtlb_hit_i(dtlb_hit_i),
    .page_offset_i(page_offset_i), .page_offset_matches_o(page_offset_matches_o),
    .amo_req_o(amo_req_o), .amo_resp_i(amo_resp_i),
    .req_port_i(req_port_i), .req_port_o(req_port_o)
  );

  typedef struct {
    logic [33:0] paddr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [1:0]  size;
  } m_st_t;

  m_st_t      m_spec[$];
  m_st_t      m_com[$];
  logic       m_held = 1'b0;
  lsu_ctrl_t  m_held_op = '0;
  logic       m_valid = 1'b0;
  logic [2:0] m_tid = '0;
  exception_t m_ex = '0;
  logic       m_acc = 1'b0;

  int total = 0;
  int bad = 0;

  logic       s_valid, s_commit, s_flush, s_hit, s_gnt;
  lsu_ctrl_t  s_op;
  exception_t s_exi;
  logic [1:0] s_hi;
  logic [11:0] s_po;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic lsu_ctrl_t mk_op(input logic [31:0] va, input logic [31:0] d,
                                      input logic [7:0] opr, input logic [2:0] tid);
    lsu_ctrl_t o;
    o = '0;
    o.valid = 1'b1;
    o.vaddr = va;
    o.data = d;
    o.be = 4'hF;
    o.fu = 4'h2;
    o.operation = opr;
    o.trans_id = tid;
    return o;
  endfunction

  function automatic lsu_ctrl_t rand_op();
    logic [31:0] va;
    logic [7:0]  opr;
    va = $urandom;
    va[11:4] = 8'($urandom_range(0, 3));
    if ($urandom_range(0, 3) != 0) va[1:0] = 2'b00;
    case ($urandom_range(0, 3))
      0: opr = 8'd39;
      1: opr = 8'd40;
      2: opr = 8'd41;
      default: opr = 8'h55;
    endcase
    return mk_op(va, $urandom, opr, 3'($urandom));
  endfunction

  task automatic idle();
    s_valid = 1'b0; s_commit = 1'b0; s_flush = 1'b0; s_hit = 1'b1; s_gnt = 1'b0;
    s_exi = '0; s_hi = 2'b00; s_po = 12'h000;
  endtask

  // Expected outputs follow from the queue contents; then the model advances one clock.
  task automatic check_cycle();
    logic       pend, mis, acc, match, do_pop, do_move;
    lsu_ctrl_t  op;
    int         sz;
    dcache_req_o_t er;
    exception_t nex;
    m_st_t      e;
    pend = m_held ? 1'b1 : valid_i;
    op   = m_held ? m_held_op : lsu_ctrl_i;
    sz   = (op.operation == 8'd40) ? 2 : (op.operation == 8'd41) ? 1 : 4;
    mis  = (op.vaddr % sz) != 0;
    acc  = pend && dtlb_hit_i && (m_spec.size() < 4) && !flush_i;
    match = acc && (op.vaddr[11:2] == page_offset_i[11:2]);
    foreach (m_spec[i]) if (m_spec[i].paddr[11:2] == page_offset_i[11:2]) match = 1'b1;
    foreach (m_com[i])  if (m_com[i].paddr[11:2]  == page_offset_i[11:2]) match = 1'b1;
    er = '0;
    if (m_com.size() > 0) begin
      er.address_index = m_com[0].paddr[11:0];
      er.address_tag   = m_com[0].paddr[33:12];
      er.data_wdata    = m_com[0].data;
      er.data_be       = m_com[0].be;
      er.data_size     = m_com[0].size;
      er.data_req = 1'b1; er.data_we = 1'b1; er.tag_valid = 1'b1;
    end
    chk("pop_st", pop_st_o, acc);
    chk("translation_req", translation_req_o, pend);
    if (pend) chk("vaddr", vaddr_o, op.vaddr);
    chk("offset_match", page_offset_matches_o, match);
    chk("req_port", req_port_o, er);
    chk("commit_ready", commit_ready_o, m_com.size() < 4);
    chk("no_st_pending", no_st_pending_o, m_com.size() == 0);
    chk("sb_empty", store_buffer_empty_o, (m_com.size() == 0) && (m_spec.size() == 0));
    chk("valid_o", valid_o, m_valid);
    chk("trans_id", trans_id_o, m_tid);
    chk("ex_o", ex_o, m_ex);
    chk("result_zero", result_o, 0);
    chk("amo_req_zero", 128'(|amo_req_o), 0);

    do_pop  = req_port_i.data_gnt && (m_com.size() > 0);
    do_move = commit_i && (m_com.size() < 4) && (m_spec.size() > 0);
    if (do_pop) void'(m_com.pop_front());
    if (do_move) m_com.push_back(m_spec.pop_front());
    if (flush_i) m_spec.delete();
    if (acc && !mis && !ex_i.valid) begin
      e.paddr = paddr_i;
      e.data  = op.data << (8 * op.vaddr[1:0]);
      e.be    = op.be;
      e.size  = (sz == 4) ? 2'd2 : (sz == 2) ? 2'd1 : 2'd0;
      m_spec.push_back(e);
    end
    nex = '0;
    if (acc && mis) begin
      nex.cause = 32'd6; nex.tval = op.vaddr; nex.valid = 1'b1;
    end else if (acc && ex_i.valid) begin
      nex = ex_i;
    end
    m_valid = acc;
    m_tid   = acc ? op.trans_id : 3'd0;
    m_ex    = nex;
    if (acc || flush_i) m_held = 1'b0;
    else if (pend) begin m_held = 1'b1; m_held_op = op; end
    m_acc = acc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    valid_i          = s_valid;
    lsu_ctrl_i       = s_op;
    lsu_ctrl_i.valid = s_valid;
    commit_i         = s_commit;
    flush_i          = s_flush;
    dtlb_hit_i       = s_hit;
    ex_i             = s_exi;
    paddr_i          = {s_hi, s_op.vaddr};
    page_offset_i    = s_po;
    req_port_i.data_gnt    = s_gnt;
    req_port_i.data_rvalid = 1'($urandom);
    req_port_i.data_rdata  = $urandom;
    req_port_i.data_ruser  = 1'b0;
    @(negedge clk);
    check_cycle();
  endtask

  logic      iss_busy;
  lsu_ctrl_t iss_op;

  initial begin
    idle();
    s_op = '0;
    rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; commit_i = 1'b0; dtlb_hit_i = 1'b0;
    amo_valid_commit_i = 1'b0; lsu_ctrl_i = '0; paddr_i = '0; ex_i = '0;
    page_offset_i = '0; amo_resp_i = '0; req_port_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_commit_ready", commit_ready_o, 1);
    chk("rst_sb_empty", store_buffer_empty_o, 1);
    chk("rst_no_st_pending", no_st_pending_o, 1);
    chk("rst_data_req", req_port_o.data_req, 0);
    chk("rst_valid_o", valid_o, 0);
    chk("rst_pop", pop_st_o, 0);
    rst_ni = 1'b1;

    // Single word store, commit and drain.
    s_valid = 1'b1; s_op = mk_op(32'h0000_1000, 32'hA5A5_A5A5, SW, 3'd5);
    step();
    chk("sw_pop", pop_st_o, 1);
    idle(); step();
    chk("sw_valid_o", valid_o, 1);
    chk("sw_trans_id", trans_id_o, 5);
    chk("sw_sb_empty", store_buffer_empty_o, 0);
    chk("sw_no_st_pending", no_st_pending_o, 1);
    s_commit = 1'b1; step();
    idle(); step();
    chk("cm_data_req", req_port_o.data_req, 1);
    chk("cm_index", req_port_o.address_index, 12'h000);
    chk("cm_tag", req_port_o.address_tag, 22'h1);
    chk("cm_wdata", req_port_o.data_wdata, 32'hA5A5_A5A5);
    s_gnt = 1'b1; step();
    idle(); step();
    chk("gnt_sb_empty", store_buffer_empty_o, 1);

    // Misaligned word store raises cause 6 and queues nothing.
    s_valid = 1'b1; s_op = mk_op(32'h0000_1002, 32'h1234_5678, SW, 3'd2);
    step();
    idle(); step();
    chk("mis_ex", ex_o, {32'd6, 32'h0000_1002, 1'b1});
    chk("mis_sb_empty", store_buffer_empty_o, 1);

    // Fill the speculative queue, then hold a fifth store until a commit frees a slot.
    for (int k = 0; k < 4; k++) begin
      s_valid = 1'b1; s_op = mk_op(32'h2000 + 32'(4 * k), $urandom, SW, 3'(k));
      step();
    end
    s_valid = 1'b1; s_op = mk_op(32'h0000_2010, 32'hCAFE_F00D, SW, 3'd7);
    step();
    chk("full_hold0", pop_st_o, 0);
    step();
    chk("full_hold1", pop_st_o, 0);
    s_commit = 1'b1; step();
    chk("full_hold2", pop_st_o, 0);
    s_commit = 1'b0; step();
    chk("full_release", pop_st_o, 1);
    idle(); s_commit = 1'b1; s_gnt = 1'b1;
    repeat (8) step();
    idle(); step();
    chk("full_drained", store_buffer_empty_o, 1);

    // Page-offset hazard match and its removal by flush.
    s_valid = 1'b1; s_op = mk_op(32'h0000_2344, 32'h0, SW, 3'd1);
    step();
    idle(); s_po = 12'h347; step();
    chk("po_match_347", page_offset_matches_o, 1);
    s_po = 12'h348; step();
    chk("po_match_348", page_offset_matches_o, 0);
    s_po = 12'h347; s_flush = 1'b1; step();
    s_flush = 1'b0; step();
    chk("po_after_flush", page_offset_matches_o, 0);

    // Randomized traffic.
    idle();
    iss_busy = 1'b0;
    iss_op = rand_op();
    for (int n = 0; n < 3000; n++) begin
      if (!iss_busy && ($urandom_range(0, 2) != 0)) begin
        iss_busy = 1'b1;
        iss_op = rand_op();
        s_hi = 2'($urandom);
      end
      s_valid  = iss_busy;
      s_op     = iss_op;
      s_hit    = ($urandom_range(0, 3) != 0);
      s_exi    = '0;
      if ($urandom_range(0, 15) == 0) begin
        s_exi.cause = $urandom; s_exi.tval = $urandom; s_exi.valid = 1'b1;
      end
      s_commit = ($urandom_range(0, 2) == 0);
      s_gnt    = 1'($urandom);
      s_flush  = ($urandom_range(0, 59) == 0);
      case ($urandom_range(0, 2))
        0: s_po = iss_op.vaddr[11:0];
        1: s_po = (m_spec.size() > 0) ? m_spec[0].paddr[11:0] : 12'($urandom);
        default: s_po = 12'($urandom);
      endcase
      step();
      if (m_acc || s_flush) iss_busy = 1'b0;
    end

    idle(); s_commit = 1'b1; s_gnt = 1'b1;
    repeat (12) step();
    idle(); step();
    chk("final_drained", store_buffer_empty_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cva6_store_unit.md
# cva6_store_unit

Store half of the CVA6 load/store unit for a 32-bit (RV32, Sv32, PLEN 34) core. Accepts store operations from issue, performs translation handshake and alignment checks, and holds stores in a speculative queue until commit. Committed stores drain to the L1 data cache through a single request port. Drives the page-offset match signal used by the load unit for store-to-load hazard checks.

## Interface
Parameters:
- DEPTH_SPEC, 4, speculative queue entries
- DEPTH_COMMIT, 4, commit queue entries
- TRANS_ID_BITS, 3; XLEN/VLEN, 32; PLEN, 34; DCACHE_INDEX_WIDTH, 12; DCACHE_TAG_WIDTH, 22

Ports (reset is asynchronous, active-low):
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  drop speculative state
- no_st_pending_o  out  1  commit queue empty
- store_buffer_empty_o  out  1  both queues empty
- valid_i  in  1  store op present
- lsu_ctrl_i  in  85  {valid, vaddr[31:0], overflow, data[31:0], be[3:0], fu[3:0], operator[7:0], trans_id[2:0]} MSB first
- pop_st_o  out  1  op consumed this cycle
- commit_i  in  1  commit oldest speculative store
- commit_ready_o  out  1  commit queue not full
- amo_valid_commit_i  in  1  unused
- valid_o  out  1  writeback valid
- trans_id_o  out  3  writeback transaction id
- result_o  out  32  always 0
- ex_o  out  65  {cause[31:0], tval[31:0], valid}
- translation_req_o  out  1  MMU request
- vaddr_o  out  32  address to MMU
- paddr_i  in  34  translated address (same cycle)
- ex_i  in  65  MMU exception, same layout as ex_o
- dtlb_hit_i  in  1  translation valid this cycle
- page_offset_i  in  12  load address offset to compare
- page_offset_matches_o  out  1  pending store hits that word
- amo_req_o  out  135  tied 0 (AMOs unsupported)
- amo_resp_i  in  65  ignored
- req_port_i  in  35  {data_gnt, data_rvalid, data_rdata[31:0], data_ruser}
- req_port_o  out  77  {address_index[11:0], address_tag[21:0], data_wdata[31:0], data_wuser, data_req, data_we, data_be[3:0], data_size[1:0], kill_req, tag_valid}

## Operation
- Operator decode: SW=39 → size 2, SH=40 → size 1, SB=41 → size 0; other operators treated as SW.
- FSM states IDLE, WAIT_TRANSLATION, WAIT_STORE_READY. In any state with a pending op: translation_req_o=1, vaddr_o=vaddr.
- Accept when dtlb_hit_i and spec queue not full: pop_st_o=1, push {paddr_i, data<<(8*vaddr[1:0]), be, size} unless exception. Miss → WAIT_TRANSLATION (op latched, pop withheld until hit). Full → WAIT_STORE_READY.
- Misaligned (SW vaddr[1:0]≠0, SH vaddr[0]≠0): no push; ex_o = {32'd6, vaddr, 1}. ex_i.valid forwarded instead when no misalignment.
- commit_i with commit_ready_o: oldest spec entry moves to commit queue tail. commit_i with empty spec queue ignored.
- Commit head drives req_port_o: data_req=1, data_we=1, index=paddr[11:0], tag=paddr[33:12], tag_valid=1, kill_req=0, wuser=0. data_gnt pops head; rvalid ignored.
- page_offset_matches_o = any valid entry (both queues) or accepting op with addr[11:2]==page_offset_i[11:2].
- flush_i: clears spec queue, FSM → IDLE, valid_o suppressed; commit queue kept.

## Timing
- Reset: all outputs 0 except commit_ready_o, no_st_pending_o, store_buffer_empty_o = 1; queues empty; FSM IDLE.
- valid_o/trans_id_o/ex_o registered: assert exactly one cycle after acceptance.
- Push, commit move and grant pop occur in the same cycle when simultaneous; entry pushed in cycle N is committable in N+1.
- Grant on head in cycle N: next entry presented in N+1.
- Queue pointers wrap modulo depth; full/empty from occupancy counters.

## Structure
- Shared package: lsu_ctrl_t, exception_t, dcache_req_i_t/o_t, amo_req_t/resp_t, fu_op constants (SW/SH/SB), STORE_ADDR_MISALIGNED=6.
- Sub-module store_buffer (both queues, commit, drain, offset match); FSM and alignment in top.

## Test plan
- Reset → commit_ready_o=1, store_buffer_empty_o=1, req_port_o.data_req=0.
- SW vaddr=0x1000, data=0xA5A5A5A5, hit → pop_st_o=1, valid_o=1 next cycle, store_buffer_empty_o=0, no_st_pending_o=1.
- Then commit_i → data_req=1, index=0x000, tag=0x1, wdata=0xA5A5A5A5; gnt → store_buffer_empty_o=1.
- SW vaddr=0x1002 → ex_o={6,0x1002,1} next cycle, nothing queued.
- 4 stores uncommitted, 5th → held, pop_st_o=0 until commit frees slot.
- Pending store 0x2344, page_offset_i=0x347 → match=1; 0x348 → 0; flush_i → 0.
